// File: rtl/mem_stage_if.sv
// EX/MEM boundary bundle: execute-side request fields and M-side results.
// The master drives the E fields and observes the M fields. mem_stage is the slave.
interface mem_stage_if;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic [2:0]  funct3E;
  logic [4:0]  rdE;
  logic [31:0] PCplus4E;
  logic [31:0] ALUResultE;
  logic [31:0] WriteDataE;

  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  rdM;
  logic [31:0] PCplus4M;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic        MisalignM;

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, funct3E, rdE, PCplus4E, ALUResultE, WriteDataE,
    input  RegWriteM, ResultSrcM, rdM, PCplus4M, ALUResultM, ReadDataM, MisalignM
  );

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, funct3E, rdE, PCplus4E, ALUResultE, WriteDataE,
    output RegWriteM, ResultSrcM, rdM, PCplus4M, ALUResultM, ReadDataM, MisalignM
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM register, word-organised data memory, store lane steering and load extension.
// One cycle E->M latency. Loads are combinational in M. There is no stall or flush.
module mem_stage #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  logic        reg_write_q, reg_write_d;
  logic [1:0]  result_src_q, result_src_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;

  assign reg_write_d  = bus.RegWriteE;
  assign result_src_d = bus.ResultSrcE;
  assign mem_write_d  = bus.MemWriteE;
  assign funct3_d     = bus.funct3E;
  assign rd_d         = bus.rdE;
  assign pc_plus4_d   = bus.PCplus4E;
  assign alu_d        = bus.ALUResultE;
  assign wdata_d      = bus.WriteDataE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      mem_write_q  <= 1'b0;
      funct3_q     <= 3'b000;
      rd_q         <= 5'd0;
      pc_plus4_q   <= 32'd0;
      alu_q        <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      mem_write_q  <= mem_write_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
    end
  end

  logic [ADDR_BITS-1:0] widx;
  logic [1:0]           offset;
  logic                 misalign;

  // Address bits above the word index are dropped, so accesses wrap modulo the memory size.
  assign widx   = alu_q[ADDR_BITS+1:2];
  assign offset = alu_q[1:0];

  always_comb begin
    misalign = 1'b0;
    if (funct3_q[1:0] == 2'b01 && offset[0])         misalign = 1'b1;
    if (funct3_q[1:0] == 2'b10 && offset != 2'b00)   misalign = 1'b1;
  end

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_word;
  logic [3:0]  byte_en;
  logic [31:0] wlane;
  logic        we;

  assign rdata_word = mem[widx];

  always_comb begin
    byte_en = 4'b0000;
    wlane   = 32'd0;
    case (funct3_q)
      3'b000: begin
        byte_en = 4'b0001 << offset;
        wlane   = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        byte_en = 4'b1111;
        wlane   = wdata_q;
      end
      default: begin
        byte_en = 4'b0000;
        wlane   = 32'd0;
      end
    endcase
  end

  assign we = mem_write_q & ~misalign & ~reset;

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && byte_en[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign byte_sel = 8'(rdata_word >> {offset, 3'b000});
  assign half_sel = offset[1] ? rdata_word[31:16] : rdata_word[15:0];

  always_comb begin
    load_data = rdata_word;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = rdata_word;
    endcase
  end

  assign bus.RegWriteM  = reg_write_q;
  assign bus.ResultSrcM = result_src_q;
  assign bus.rdM        = rd_q;
  assign bus.PCplus4M   = pc_plus4_q;
  assign bus.ALUResultM = alu_q;
  assign bus.ReadDataM  = load_data;
  assign bus.MisalignM  = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset sequences, then random traffic against a byte-array model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset;

  mem_stage_if bus ();

  mem_stage #(.DEPTH(1024), .ADDR_BITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Byte-addressed model of the 4 KiB data memory plus the access currently in M.
  logic [7:0]  mb [4096];
  logic        m_rw;
  logic [1:0]  m_rs;
  logic        m_mw;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_alu, m_wd;

  typedef struct {
    logic [2:0]  f3;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  rs;
    logic [31:0] pc;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t V(logic [2:0] f3, logic mw, logic [31:0] addr, logic [31:0] wd,
                             logic [1:0] rs, logic [31:0] pc, logic chk_rd, logic [31:0] exp_rd,
                             logic exp_mis);
    vec_t v;
    v.f3 = f3; v.mw = mw; v.addr = addr; v.wd = wd; v.rs = rs; v.pc = pc;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    return v;
  endfunction

  function automatic logic model_mis(logic [2:0] f3, logic [31:0] a);
    return (f3[1:0] == 2'd1 && (a % 2) != 0) || (f3[1:0] == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a);
    int ba, ha, wa;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    ba = int'(a[11:0]);
    ha = ba - (ba % 2);
    wa = ba - (ba % 4);
    b = mb[ba];
    h = {mb[ha+1], mb[ha]};
    w = {mb[wa+3], mb[wa+2], mb[wa+1], mb[wa]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_commit();
    int ba, ha, wa;
    ba = int'(m_alu[11:0]);
    ha = ba - (ba % 2);
    wa = ba - (ba % 4);
    if (m_mw && !model_mis(m_f3, m_alu)) begin
      case (m_f3)
        3'd0: mb[ba] = m_wd[7:0];
        3'd1: begin mb[ha] = m_wd[7:0]; mb[ha+1] = m_wd[15:8]; end
        3'd2: begin
          mb[wa] = m_wd[7:0];    mb[wa+1] = m_wd[15:8];
          mb[wa+2] = m_wd[23:16]; mb[wa+3] = m_wd[31:24];
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_clear();
    m_rw = 1'b0; m_rs = 2'd0; m_mw = 1'b0; m_f3 = 3'd0; m_rd = 5'd0;
    m_pc = 32'd0; m_alu = 32'd0; m_wd = 32'd0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic rw, logic [1:0] rs, logic mw, logic [2:0] f3, logic [4:0] rd,
                       logic [31:0] pc, logic [31:0] alu, logic [31:0] wd);
    bus.RegWriteE = rw; bus.ResultSrcE = rs; bus.MemWriteE = mw; bus.funct3E = f3;
    bus.rdE = rd; bus.PCplus4E = pc; bus.ALUResultE = alu; bus.WriteDataE = wd;
  endtask

  // Advance one clock: the model retires the store held in M, then takes the E inputs.
  task automatic tick();
    if (reset) model_clear();
    else begin
      model_commit();
      m_rw = bus.RegWriteE; m_rs = bus.ResultSrcE; m_mw = bus.MemWriteE; m_f3 = bus.funct3E;
      m_rd = bus.rdE; m_pc = bus.PCplus4E; m_alu = bus.ALUResultE; m_wd = bus.WriteDataE;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".ReadDataM"},  bus.ReadDataM,  model_load(m_f3, m_alu));
    chk({tag, ".MisalignM"},  32'(bus.MisalignM), 32'(model_mis(m_f3, m_alu)));
    chk({tag, ".rdM"},        32'(bus.rdM),   32'(m_rd));
    chk({tag, ".RegWriteM"},  32'(bus.RegWriteM), 32'(m_rw));
    chk({tag, ".ResultSrcM"}, 32'(bus.ResultSrcM), 32'(m_rs));
    chk({tag, ".PCplus4M"},   bus.PCplus4M,   m_pc);
    chk({tag, ".ALUResultM"}, bus.ALUResultM, m_alu);
  endtask

  vec_t vecs [$];

  initial begin
    model_clear();
    reset = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 3'd0, 5'd5, 32'h0, 32'h44, 32'h0);
    #2;
    chk("rst0.rdM", 32'(bus.rdM), 32'd0);
    chk("rst0.RegWriteM", 32'(bus.RegWriteM), 32'd0);
    chk("rst0.ALUResultM", bus.ALUResultM, 32'd0);
    chk("rst0.MisalignM", 32'(bus.MisalignM), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst0_rel.rdM", 32'(bus.rdM), 32'd5);
    chk("rst0_rel.RegWriteM", 32'(bus.RegWriteM), 32'd1);

    // Give the low 64 bytes known contents so the model can predict every read there.
    for (int w = 0; w < 16; w++) begin
      drive(1'b0, 2'd0, 1'b1, 3'd2, 5'd0, 32'h0, 32'(w * 4), 32'h0);
      tick();
    end

    vecs.push_back(V(3'd2, 1, 32'h10,   32'hDEADBEEF, 2'd0, 32'h200, 0, 32'h0,        0));
    vecs.push_back(V(3'd2, 0, 32'h10,   32'h0,        2'd1, 32'h204, 1, 32'hDEADBEEF, 0));
    vecs.push_back(V(3'd4, 0, 32'h13,   32'h0,        2'd1, 32'h208, 1, 32'h000000DE, 0));
    vecs.push_back(V(3'd0, 0, 32'h13,   32'h0,        2'd1, 32'h20C, 1, 32'hFFFFFFDE, 0));
    vecs.push_back(V(3'd5, 0, 32'h12,   32'h0,        2'd1, 32'h210, 1, 32'h0000DEAD, 0));
    vecs.push_back(V(3'd1, 0, 32'h10,   32'h0,        2'd1, 32'h214, 1, 32'hFFFFBEEF, 0));
    vecs.push_back(V(3'd0, 1, 32'h11,   32'h55,       2'd0, 32'h218, 0, 32'h0,        0));
    vecs.push_back(V(3'd2, 0, 32'h10,   32'h0,        2'd1, 32'h21C, 1, 32'hDEAD55EF, 0));
    vecs.push_back(V(3'd1, 1, 32'h12,   32'h1234,     2'd0, 32'h220, 0, 32'h0,        0));
    vecs.push_back(V(3'd2, 0, 32'h10,   32'h0,        2'd1, 32'h224, 1, 32'h123455EF, 0));
    vecs.push_back(V(3'd2, 1, 32'h22,   32'hFFFFFFFF, 2'd0, 32'h228, 0, 32'h0,        1));
    vecs.push_back(V(3'd2, 0, 32'h20,   32'h0,        2'd1, 32'h22C, 1, 32'h0,        0));
    vecs.push_back(V(3'd1, 1, 32'h21,   32'hFFFF,     2'd0, 32'h230, 0, 32'h0,        1));
    vecs.push_back(V(3'd2, 0, 32'h20,   32'h0,        2'd1, 32'h234, 1, 32'h0,        0));
    vecs.push_back(V(3'd2, 1, 32'h1000, 32'hA5A5A5A5, 2'd0, 32'h238, 0, 32'h0,        0));
    vecs.push_back(V(3'd2, 0, 32'h0,    32'h0,        2'd1, 32'h23C, 1, 32'hA5A5A5A5, 0));
    vecs.push_back(V(3'd2, 1, 32'h30,   32'h11111111, 2'd0, 32'h240, 1, 32'h0,        0));
    vecs.push_back(V(3'd2, 0, 32'h30,   32'h0,        2'd1, 32'h244, 1, 32'h11111111, 0));
    vecs.push_back(V(3'd0, 0, 32'h8,    32'h0,        2'd2, 32'h104, 0, 32'h0,        0));
    vecs.push_back(V(3'd2, 0, 32'h8,    32'h0,        2'd1, 32'h248, 1, 32'h0,        0));

    foreach (vecs[i]) begin
      drive(1'(i % 2), vecs[i].rs, vecs[i].mw, vecs[i].f3, 5'(i), vecs[i].pc,
            vecs[i].addr, vecs[i].wd);
      tick();
      if (vecs[i].chk_rd) chk($sformatf("vec%0d.ReadDataM", i), bus.ReadDataM, vecs[i].exp_rd);
      chk($sformatf("vec%0d.MisalignM", i), 32'(bus.MisalignM), 32'(vecs[i].exp_mis));
      chk($sformatf("vec%0d.rdM", i), 32'(bus.rdM), 32'(i));
      chk($sformatf("vec%0d.RegWriteM", i), 32'(bus.RegWriteM), 32'(i % 2));
      chk($sformatf("vec%0d.ResultSrcM", i), 32'(bus.ResultSrcM), 32'(vecs[i].rs));
      chk($sformatf("vec%0d.PCplus4M", i), bus.PCplus4M, vecs[i].pc);
      chk($sformatf("vec%0d.ALUResultM", i), bus.ALUResultM, vecs[i].addr);
    end

    // Mid-run asynchronous reset: fields clear between edges, load shows LB of word 0.
    drive(1'b1, 2'd1, 1'b0, 3'd2, 5'd5, 32'h8, 32'h46, 32'h0);
    tick();
    chk("rst1.pre.rdM", 32'(bus.rdM), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("rst1.rdM", 32'(bus.rdM), 32'd0);
    chk("rst1.RegWriteM", 32'(bus.RegWriteM), 32'd0);
    chk("rst1.ALUResultM", bus.ALUResultM, 32'd0);
    chk("rst1.PCplus4M", bus.PCplus4M, 32'd0);
    chk("rst1.ResultSrcM", 32'(bus.ResultSrcM), 32'd0);
    chk("rst1.MisalignM", 32'(bus.MisalignM), 32'd0);
    chk("rst1.ReadDataM", bus.ReadDataM, 32'hFFFFFFA5);
    model_clear();
    reset = 1'b0;
    tick();
    chk("rst1_rel.rdM", 32'(bus.rdM), 32'd5);
    chk("rst1_rel.RegWriteM", 32'(bus.RegWriteM), 32'd1);

    // Store sitting in M when reset hits must not reach memory.
    drive(1'b0, 2'd0, 1'b1, 3'd2, 5'd0, 32'h0, 32'h4, 32'h12345678);
    tick();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 2'd1, 1'b0, 3'd2, 5'd0, 32'h0, 32'h4, 32'h0);
    tick();
    chk("rst_store.ReadDataM", bus.ReadDataM, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = $urandom;
      a = a & 32'hFFFFF03F;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, a, $urandom);
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
